// File: rtl/symbol_error_counter.sv
// Windowed symbol/error counter for BER measurement. Windows are delimited by rising
// edges of clear_accumulator; totals latch at each boundary once the settle phase ends.
module symbol_error_counter #(
   parameter int CNT_W          = 22,
   parameter int SETTLE_PERIODS = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sym_clk_ena,
   input  logic             sym_correct,
   input  logic             sym_error,
   input  logic             clear_accumulator,
   output logic [CNT_W-1:0] err_total,
   output logic [CNT_W-1:0] sym_total,
   output logic             result_valid,
   output logic             error_free,
   output logic [7:0]       period_count,
   output logic             protocol_err,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      COUNT  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [15:0]      SETTLE_INIT = 16'(SETTLE_PERIODS);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && (v != CNT_MAX)) begin
         return v + CNT_W'(1);
      end else begin
         return v;
      end
   endfunction

   state_e           state_q, state_d;
   logic [15:0]      settle_q, settle_d;
   logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] sym_total_q, sym_total_d;
   logic [CNT_W-1:0] err_total_q, err_total_d;
   logic             result_valid_q, result_valid_d;
   logic             error_free_q, error_free_d;
   logic [7:0]       period_count_q, period_count_d;
   logic             protocol_err_q, protocol_err_d;
   logic             clr_prev_q;

   logic             boundary_s;
   logic             count_s;
   logic             err_s;
   logic             illegal_s;
   logic [CNT_W-1:0] sym_inc_s;
   logic [CNT_W-1:0] err_inc_s;

   // A symbol with both flags set counts as an error; with neither it is dropped.
   assign boundary_s = clear_accumulator & ~clr_prev_q;
   assign count_s    = sym_clk_ena & (sym_correct | sym_error);
   assign err_s      = sym_clk_ena & sym_error;
   assign illegal_s  = sym_clk_ena & ~(sym_correct ^ sym_error);
   assign sym_inc_s  = sat_inc(sym_cnt_q, count_s);
   assign err_inc_s  = sat_inc(err_cnt_q, err_s);

   // Next-state logic for the window FSM, counters and latched results
   always_comb begin
      state_d        = state_q;
      settle_d       = settle_q;
      sym_cnt_d      = sym_cnt_q;
      err_cnt_d      = err_cnt_q;
      sym_total_d    = sym_total_q;
      err_total_d    = err_total_q;
      result_valid_d = 1'b0;
      error_free_d   = error_free_q;
      period_count_d = period_count_q;
      protocol_err_d = protocol_err_q | illegal_s;
      case (state_q)
         IDLE: begin
            if (boundary_s) begin
               if (SETTLE_PERIODS > 0) begin
                  state_d  = SETTLE;
                  settle_d = SETTLE_INIT;
               end else begin
                  state_d  = COUNT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SETTLE: begin
            if (boundary_s) begin
               if (settle_q <= 16'd1) begin
                  state_d  = COUNT;
                  settle_d = 16'd0;
               end else begin
                  settle_d = settle_q - 16'd1;
               end
            end else begin
               state_d = SETTLE;
            end
         end
         COUNT: begin
            if (boundary_s) begin
               sym_total_d    = sym_inc_s;
               err_total_d    = err_inc_s;
               sym_cnt_d      = '0;
               err_cnt_d      = '0;
               result_valid_d = 1'b1;
               error_free_d   = (err_inc_s == '0);
               if (period_count_q != 8'd255) begin
                  period_count_d = period_count_q + 8'd1;
               end else begin
                  period_count_d = period_count_q;
               end
            end else begin
               sym_cnt_d = sym_inc_s;
               err_cnt_d = err_inc_s;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; previous-clear resets high so a level held through reset is not an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         settle_q       <= 16'd0;
         sym_cnt_q      <= '0;
         err_cnt_q      <= '0;
         sym_total_q    <= '0;
         err_total_q    <= '0;
         result_valid_q <= 1'b0;
         error_free_q   <= 1'b0;
         period_count_q <= 8'd0;
         protocol_err_q <= 1'b0;
         clr_prev_q     <= 1'b1;
      end else begin
         state_q        <= state_d;
         settle_q       <= settle_d;
         sym_cnt_q      <= sym_cnt_d;
         err_cnt_q      <= err_cnt_d;
         sym_total_q    <= sym_total_d;
         err_total_q    <= err_total_d;
         result_valid_q <= result_valid_d;
         error_free_q   <= error_free_d;
         period_count_q <= period_count_d;
         protocol_err_q <= protocol_err_d;
         clr_prev_q     <= clear_accumulator;
      end
   end

   assign err_total    = err_total_q;
   assign sym_total    = sym_total_q;
   assign result_valid = result_valid_q;
   assign error_free   = error_free_q;
   assign period_count = period_count_q;
   assign protocol_err = protocol_err_q;
   assign state        = state_q;

endmodule

// File: tb/tb_symbol_error_counter.sv
// Bench for symbol_error_counter: two instances (22-bit/settle 1 and 4-bit/settle 0)
// share stimulus and are compared every cycle against a boundary-counting reference model.
module tb_symbol_error_counter;

   logic clk = 1'b0;
   logic reset_n, sym_clk_ena, sym_correct, sym_error, clear_accumulator;

   logic [21:0] err_total_a, sym_total_a;
   logic        rv_a, ef_a, perr_a;
   logic [7:0]  pc_a;
   logic [1:0]  st_a;
   logic [3:0]  err_total_b, sym_total_b;
   logic        rv_b, ef_b, perr_b;
   logic [7:0]  pc_b;
   logic [1:0]  st_b;

   always #5 clk = ~clk;

   symbol_error_counter #(.CNT_W(22), .SETTLE_PERIODS(1)) dut (
      .clk(clk), .reset_n(reset_n), .sym_clk_ena(sym_clk_ena), .sym_correct(sym_correct),
      .sym_error(sym_error), .clear_accumulator(clear_accumulator),
      .err_total(err_total_a), .sym_total(sym_total_a), .result_valid(rv_a),
      .error_free(ef_a), .period_count(pc_a), .protocol_err(perr_a), .state(st_a));

   symbol_error_counter #(.CNT_W(4), .SETTLE_PERIODS(0)) dut4 (
      .clk(clk), .reset_n(reset_n), .sym_clk_ena(sym_clk_ena), .sym_correct(sym_correct),
      .sym_error(sym_error), .clear_accumulator(clear_accumulator),
      .err_total(err_total_b), .sym_total(sym_total_b), .result_valid(rv_b),
      .error_free(ef_b), .period_count(pc_b), .protocol_err(perr_b), .state(st_b));

   int errors = 0;
   int checks = 0;
   int rv_seen_a = 0;
   int rv_seen_b = 0;

   // Reference model: state follows from how many boundaries have been seen since reset.
   int     m_w[2]      = '{22, 4};
   int     m_settle[2] = '{1, 0};
   longint m_bounds[2], m_wsym[2], m_werr[2], m_sym_tot[2], m_err_tot[2];
   int     m_pc[2];
   bit     m_rv[2], m_ef[2], m_perr[2];
   bit     m_prev_clr;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_bounds[i] = 0; m_wsym[i] = 0; m_werr[i] = 0;
         m_sym_tot[i] = 0; m_err_tot[i] = 0; m_pc[i] = 0;
         m_rv[i] = 1'b0; m_ef[i] = 1'b0; m_perr[i] = 1'b0;
      end
      m_prev_clr = 1'b1;
   endfunction

   function automatic void model_step();
      bit bnd;
      bnd = clear_accumulator && !m_prev_clr;
      m_prev_clr = clear_accumulator;
      for (int i = 0; i < 2; i++) begin
         bit     counting;
         longint maxv;
         counting = (m_bounds[i] > m_settle[i]);
         maxv = (longint'(1) << m_w[i]) - 1;
         m_rv[i] = 1'b0;
         if (sym_clk_ena && (sym_correct || sym_error) && counting) begin
            m_wsym[i]++;
            if (sym_error) m_werr[i]++;
         end
         if (sym_clk_ena && (sym_correct == sym_error)) m_perr[i] = 1'b1;
         if (bnd) begin
            if (counting) begin
               m_sym_tot[i] = (m_wsym[i] > maxv) ? maxv : m_wsym[i];
               m_err_tot[i] = (m_werr[i] > maxv) ? maxv : m_werr[i];
               m_rv[i] = 1'b1;
               m_ef[i] = (m_err_tot[i] == 0);
               if (m_pc[i] < 255) m_pc[i]++;
               m_wsym[i] = 0;
               m_werr[i] = 0;
            end
            m_bounds[i]++;
         end
      end
   endfunction

   function automatic int exp_state(input int i);
      if (m_bounds[i] == 0) return 0;
      else if (m_bounds[i] <= m_settle[i]) return 1;
      else return 2;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("a_err_total", 64'(err_total_a), 64'(m_err_tot[0]));
      chk("a_sym_total", 64'(sym_total_a), 64'(m_sym_tot[0]));
      chk("a_result_valid", 64'(rv_a), 64'(m_rv[0]));
      chk("a_error_free", 64'(ef_a), 64'(m_ef[0]));
      chk("a_period_count", 64'(pc_a), 64'(m_pc[0]));
      chk("a_protocol_err", 64'(perr_a), 64'(m_perr[0]));
      chk("a_state", 64'(st_a), 64'(exp_state(0)));
      chk("b_err_total", 64'(err_total_b), 64'(m_err_tot[1]));
      chk("b_sym_total", 64'(sym_total_b), 64'(m_sym_tot[1]));
      chk("b_result_valid", 64'(rv_b), 64'(m_rv[1]));
      chk("b_error_free", 64'(ef_b), 64'(m_ef[1]));
      chk("b_period_count", 64'(pc_b), 64'(m_pc[1]));
      chk("b_protocol_err", 64'(perr_b), 64'(m_perr[1]));
      chk("b_state", 64'(st_b), 64'(exp_state(1)));
      if (rv_a === 1'b1) rv_seen_a++;
      if (rv_b === 1'b1) rv_seen_b++;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step();
      #1;
      check_all();
   endtask

   task automatic drive(input bit e, input bit c, input bit r, input bit cl);
      sym_clk_ena = e; sym_correct = c; sym_error = r; clear_accumulator = cl;
      tick();
   endtask

   // nsym legal symbols, nerr of them errors at random positions, random idle gaps with junk flags
   task automatic window(input int nsym, input int nerr);
      int errs_left;
      errs_left = nerr;
      for (int k = 0; k < nsym; k++) begin
         bit is_err;
         is_err = (errs_left > 0) && (int'($urandom_range(nsym - k - 1)) < errs_left);
         if (is_err) errs_left--;
         drive(1'b1, !is_err, is_err, 1'b0);
         repeat ($urandom_range(2)) drive(1'b0, 1'($urandom), 1'($urandom), 1'b0);
      end
   endtask

   initial begin
      bit cl;
      reset_n = 1'b0; sym_clk_ena = 1'b0; sym_correct = 1'b0; sym_error = 1'b0;
      clear_accumulator = 1'b0;
      model_reset();
      repeat (3) tick();
      reset_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);

      // Three windows: IDLE, SETTLE, then the first counted window with 5 errors
      rv_seen_a = 0;
      window(100, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      window(100, 3);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      window(100, 5);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("s1_rv", 64'(rv_a), 64'd1);
      chk("s1_err_total", 64'(err_total_a), 64'd5);
      chk("s1_sym_total", 64'(sym_total_a), 64'd100);
      chk("s1_period_count", 64'(pc_a), 64'd1);
      chk("s1_error_free", 64'(ef_a), 64'd0);
      chk("s1_b_sym_total_sat", 64'(sym_total_b), 64'd15);
      chk("s1_b_period_count", 64'(pc_b), 64'd2);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("s1_rv_pulses", 64'(rv_seen_a), 64'd1);

      // Held-high clear produces one boundary only
      rv_seen_a = 0;
      repeat (40) drive(1'b1, 1'b1, 1'b0, 1'b1);
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("s2_rv_pulses", 64'(rv_seen_a), 64'd1);
      chk("s2_period_count", 64'(pc_a), 64'd2);

      // Error symbol on the boundary cycle belongs to the closing window
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      window(10, 2);
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      chk("s3_rv", 64'(rv_a), 64'd1);
      chk("s3_err_total", 64'(err_total_a), 64'd3);
      chk("s3_sym_total", 64'(sym_total_a), 64'd11);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("s3_next_sym_total", 64'(sym_total_a), 64'd0);
      chk("s3_next_err_total", 64'(err_total_a), 64'd0);
      chk("s3_error_free", 64'(ef_a), 64'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);

      // Saturation on the 4-bit instance
      window(20, 20);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("s4_b_err_total", 64'(err_total_b), 64'd15);
      chk("s4_b_sym_total", 64'(sym_total_b), 64'd15);
      chk("s4_a_err_total", 64'(err_total_a), 64'd20);
      drive(1'b0, 1'b0, 1'b0, 1'b0);

      // Illegal comparator inputs
      chk("s5_no_perr_yet", 64'(perr_a), 64'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("s5_perr_neither", 64'(perr_a), 64'd1);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("s5_err_total", 64'(err_total_a), 64'd1);
      chk("s5_sym_total", 64'(sym_total_a), 64'd4);
      repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("s5_perr_sticky", 64'(perr_a), 64'd1);

      // Reset mid-window with clear already high at release
      window(7, 1);
      reset_n = 1'b0;
      clear_accumulator = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("s6_async_state", 64'(st_a), 64'd0);
      chk("s6_async_sym_total", 64'(sym_total_a), 64'd0);
      repeat (3) tick();
      reset_n = 1'b1;
      rv_seen_a = 0;
      repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("s6_idle_held", 64'(st_a), 64'd0);
      chk("s6_perr_cleared", 64'(perr_a), 64'd0);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      chk("s6_perr_both", 64'(perr_a), 64'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("s6_a_state_settle", 64'(st_a), 64'd1);
      chk("s6_b_state_count", 64'(st_b), 64'd2);
      chk("s6_no_rv", 64'(rv_seen_a), 64'd0);

      // Random soak
      cl = 1'b1;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(9) == 0) cl = ~cl;
         drive(1'($urandom), 1'($urandom), 1'($urandom), cl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/symbol_error_counter.md
SYMBOL_ERROR_COUNTER -- requirements
Module: symbol_error_counter

Interface
REQ-001 Parameter CNT_W, default 22: width of the per-window symbol and error counters.
REQ-002 Parameter SETTLE_PERIODS, default 1: number of window boundaries ignored after reset while the magnitude estimate converges.
REQ-003 Port clk, input, 1: system clock; the block is clocked by sys_clk.
REQ-004 Port reset_n, input, 1: reset; one clock; reset is asynchronous and active-low.
REQ-005 Port sym_clk_ena, input, 1: symbol-rate enable, one clk cycle wide.
REQ-006 Port sym_correct, input, 1: comparator reports slicer decision matches transmitted symbol; valid only while sym_clk_ena=1.
REQ-007 Port sym_error, input, 1: comparator reports a symbol mismatch; valid only while sym_clk_ena=1.
REQ-008 Port clear_accumulator, input, 1: LFSR period marker; a level that may stay high for several clk cycles.
REQ-009 Port err_total, output, CNT_W: error count latched at the end of the last window.
REQ-010 Port sym_total, output, CNT_W: symbol count latched at the end of the last window.
REQ-011 Port result_valid, output, 1: one-cycle pulse when err_total and sym_total update.
REQ-012 Port error_free, output, 1: high while the latched err_total is 0 and at least one result exists.
REQ-013 Port period_count, output, 8: number of completed windows; saturates at 255.
REQ-014 Port protocol_err, output, 1: sticky flag for illegal comparator input.
REQ-015 Port state, output, 2: current FSM state (IDLE=0, SETTLE=1, COUNT=2).

Function
REQ-016 Window boundary: the block SHALL detect a boundary as the clk cycle where clear_accumulator is 1 and was 0 on the previous cycle; a held high level SHALL produce exactly one boundary.
REQ-017 IDLE: entered on reset; on the first boundary, go to SETTLE if SETTLE_PERIODS>0, else go to COUNT.
REQ-018 SETTLE: each boundary decrements the settle counter; when SETTLE_PERIODS boundaries have been seen since leaving IDLE, go to COUNT.
REQ-019 IDLE and SETTLE: symbols are not counted, and result_valid stays 0.
REQ-020 Valid symbol: sym_clk_ena=1 with exactly one of sym_correct or sym_error set.
REQ-021 COUNT, each valid symbol: sym_cnt += 1; err_cnt += 1 if sym_error=1.
REQ-022 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 Illegal symbol: sym_clk_ena=1 with both flags set, or with neither set.
REQ-024 Both flags set: protocol_err is set, and in COUNT the symbol is counted as an error.
REQ-025 Neither flag set: protocol_err is set, and the symbol is not counted.
REQ-026 sym_correct or sym_error high while sym_clk_ena=0: ignored, no flag.
REQ-027 COUNT, on a boundary, the block SHALL:
- latch err_total and sym_total, including any valid symbol on that same cycle, which belongs to the closing window;
- pulse result_valid on the next cycle, aligned with the updated totals;
- restart sym_cnt and err_cnt at 0 on the next cycle;
- increment period_count (saturating);
- remain in COUNT.
REQ-028 Latency: boundary cycle N -> err_total, sym_total and result_valid visible at cycle N+1; error_free valid at the same cycle.
REQ-029 error_free SHALL be 0 until the first result_valid pulse.
REQ-030 protocol_err is cleared only by reset.

Reset
REQ-031 While reset_n=0, the block SHALL force, regardless of clk:
- state=IDLE;
- all counters, err_total, sym_total and period_count = 0;
- result_valid, error_free and protocol_err = 0;
- previous-clear_accumulator register = 1, so a clear_accumulator already high at reset release is not a boundary.
REQ-032 Reset asserted mid-window SHALL discard the partial counts, and no result_valid pulse SHALL be produced.
REQ-033 After reset_n rises, the first boundary detected SHALL be the next 0->1 transition of clear_accumulator.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- SETTLE_PERIODS=1; release reset; 3 boundaries with 100 legal symbols each, 5 errors in window 3 -> result_valid once, err_total=5, sym_total=100, period_count=1, error_free=0.
- clear_accumulator held high 40 cycles in COUNT -> exactly one result_valid, period_count +1.
- Valid error symbol on the boundary cycle -> counted in the closing window; the new window starts at sym_total=0.
- CNT_W=4, 20 error symbols in one window -> err_total=15, sym_total=15, no wrap.
- sym_clk_ena with both flags set -> protocol_err=1 and error counted; with neither set -> protocol_err=1 and no count; flag persists until reset.
- reset_n low mid-window with clear_accumulator high at release -> all outputs 0, state=IDLE, no boundary until clear_accumulator goes 0 then 1.
